// File: rtl/fe_power_seq_if.sv
`default_nettype none
// ============================================================================
// fe_power_seq_if : host-side request/status bundle for fe_power_seq
// Optional: FE_SEQ_OC_COUNT_EN adds the oc_count fault-event counters
// Rev 1.0
// ============================================================================
interface fe_power_seq_if;
  logic [7:0]  req_target;
  logic        req_valid;
  logic        req_ready;
  logic        suspend;
  logic        ci_overcurrent_n;
  logic        tps_overcurrent_n;
  logic        fault_clr;
  logic [7:0]  ctrl_out;
  logic        busy;
  logic        done;
  logic [1:0]  fault;
`ifdef FE_SEQ_OC_COUNT_EN
  logic [15:0] oc_count;
`endif

  modport master (
    output req_target, req_valid, suspend, ci_overcurrent_n, tps_overcurrent_n, fault_clr,
    input  req_ready, ctrl_out, busy, done, fault
`ifdef FE_SEQ_OC_COUNT_EN
    , input oc_count
`endif
  );

  modport slave (
    input  req_target, req_valid, suspend, ci_overcurrent_n, tps_overcurrent_n, fault_clr,
    output req_ready, ctrl_out, busy, done, fault
`ifdef FE_SEQ_OC_COUNT_EN
    , output oc_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fe_power_seq.sv
`default_nettype none
// ============================================================================
// fe_power_seq : orders frontend power, reset and I2C-gate release on reset_ctrl
// Optional: FE_SEQ_OC_COUNT_EN adds oc_count (CI events [7:0], TPS events [15:8])
// Rev 1.0
// ============================================================================
module fe_power_seq #(
  parameter int PWR_SETTLE = 600000,
  parameter int RST_GAP    = 60000,
  parameter int OC_FILTER  = 16,
  parameter int CNT_W      = 20
) (
  input  logic          clk,
  input  logic          reset,
  fe_power_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PWR_WAIT  = 3'd2,
    S_RST       = 3'd3,
    S_RST_WAIT  = 3'd4,
    S_GATE_WAIT = 3'd5,
    S_SUSP      = 3'd6
  } state_t;

  localparam int               OC_W     = $clog2(OC_FILTER + 1);
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(RST_GAP - 1);
  localparam logic [OC_W-1:0]  OC_MAX   = OC_W'(OC_FILTER);

  state_t           state_q, state_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [7:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_q, fault_d;
  logic             done_q, done_d;
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [OC_W-1:0]  ci_cnt_q, ci_cnt_d, tps_cnt_q, tps_cnt_d;

  logic [1:0] oc_hit;
  logic [7:0] eff;
  logic [7:0] rel_mask;
  logic [3:0] rel_lo;
  logic       req_ok;
  logic       step_now;
  logic       from_wait;

  // Index 0 is CI (power bit 6), index 1 is TPS (antenna bit 5).
  always_comb begin
    sync1_d   = {bus.tps_overcurrent_n, bus.ci_overcurrent_n};
    sync2_d   = sync1_q;
    ci_cnt_d  = sync2_q[0] ? '0 : ((ci_cnt_q == OC_MAX) ? ci_cnt_q : ci_cnt_q + OC_W'(1));
    tps_cnt_d = sync2_q[1] ? '0 : ((tps_cnt_q == OC_MAX) ? tps_cnt_q : tps_cnt_q + OC_W'(1));
    oc_hit    = {tps_cnt_d == OC_MAX, ci_cnt_d == OC_MAX};
    fault_d   = (bus.fault_clr ? 2'b00 : fault_q) | oc_hit;
  end

  assign eff      = target_q | {1'b0, fault_q[0], fault_q[1], 5'b0};
  assign rel_mask = ctrl_q & ~eff;
  assign rel_lo   = rel_mask[3:0] & (~rel_mask[3:0] + 4'd1);
  assign req_ok   = (state_q == S_IDLE) && !bus.suspend;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    step_now  = 1'b0;
    from_wait = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ok) begin
          target_d = bus.req_target;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        ctrl_d    = ctrl_q | eff;
        ctrl_d[4] = eff[4];
        state_d   = (|rel_mask[6:5]) ? S_PWR_WAIT : S_RST;
      end
      S_PWR_WAIT: begin
        // Power edge happens on the first wait cycle; the settle count starts there.
        if (|rel_mask[6:5]) begin
          ctrl_d[6:5] = ctrl_q[6:5] & eff[6:5];
          cnt_d       = PWR_LOAD;
        end else if (cnt_q == '0) begin
          step_now  = 1'b1;
          from_wait = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RST: step_now = 1'b1;
      S_RST_WAIT: begin
        if (cnt_q == '0) begin
          step_now  = 1'b1;
          from_wait = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GATE_WAIT: begin
        if (cnt_q == '0) begin
          ctrl_d[7] = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SUSP: begin
        if (!bus.suspend) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Releases land on the cycle a gap expires, so spacing is exactly the gap length.
    if (step_now) begin
      if (|rel_mask[3:0]) begin
        ctrl_d[3:0] = ctrl_q[3:0] & ~rel_lo;
        cnt_d       = GAP_LOAD;
        state_d     = S_RST_WAIT;
      end else if (rel_mask[7] && from_wait) begin
        ctrl_d[7] = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end else if (rel_mask[7]) begin
        cnt_d   = GAP_LOAD;
        state_d = S_GATE_WAIT;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (bus.suspend) begin
      ctrl_d  = 8'hFF;
      state_d = S_SUSP;
      done_d  = 1'b0;
    end

    ctrl_d[6] = ctrl_d[6] | oc_hit[0];
    ctrl_d[5] = ctrl_d[5] | oc_hit[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 8'hFF;
      target_q  <= 8'hFF;
      cnt_q     <= '0;
      fault_q   <= 2'b00;
      done_q    <= 1'b0;
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      ci_cnt_q  <= '0;
      tps_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      done_q    <= done_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ci_cnt_q  <= ci_cnt_d;
      tps_cnt_q <= tps_cnt_d;
    end
  end

  assign bus.req_ready = req_ok;
  assign bus.ctrl_out  = ctrl_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

`ifdef FE_SEQ_OC_COUNT_EN
  logic [15:0] oc_count_q, oc_count_d;
  logic [1:0]  fault_rise;

  assign fault_rise = fault_d & ~fault_q;

  always_comb begin
    oc_count_d = oc_count_q;
    if (fault_rise[0] && (oc_count_q[7:0] != 8'hFF))  oc_count_d[7:0]  = oc_count_q[7:0] + 8'd1;
    if (fault_rise[1] && (oc_count_q[15:8] != 8'hFF)) oc_count_d[15:8] = oc_count_q[15:8] + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) oc_count_q <= 16'h0000;
    else       oc_count_q <= oc_count_d;
  end

  assign bus.oc_count = oc_count_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fe_power_seq.sv
`default_nettype none
// ============================================================================
// tb_fe_power_seq : directed + randomized check of fe_power_seq against a timeline model
// Rev 1.0
// ============================================================================
module tb_fe_power_seq;
  localparam int PS = 8;
  localparam int RG = 4;
  localparam int OF = 3;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] m_ctrl;

  fe_power_seq_if bus ();

  fe_power_seq #(
    .PWR_SETTLE(PS),
    .RST_GAP(RG),
    .OC_FILTER(OF),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timeline model: LOAD at t=1, optional power edge at t=2, then releases spaced by the gaps.
  task automatic run_seq(input logic [7:0] eff, input int stop_t, input bit junk);
    logic [7:0] v, cur, expc, pw;
    int         t_rel[5];
    logic [7:0] v_rel[5];
    int         n, s, t_done, t_last;
    v    = m_ctrl | eff;
    v[4] = eff[4];
    pw   = m_ctrl & ~eff & 8'h60;
    s    = (pw != 8'h00) ? 2 + PS : 2;
    cur  = v & ~pw;
    n    = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !eff[i]) begin
        cur[i]   = 1'b0;
        t_rel[n] = s + n * RG;
        v_rel[n] = cur;
        n++;
      end
    end
    t_done = (n > 0) ? s + n * RG : s;
    if (v[7] && !eff[7]) begin
      cur[7] = 1'b0;
      if (n == 0 && pw == 8'h00) t_done = s + RG;
      t_rel[n] = t_done;
      v_rel[n] = cur;
      n++;
    end
    t_last = (stop_t > 0) ? stop_t : t_done;
    expc   = m_ctrl;
    chk("ctrl@t0", 16'(bus.ctrl_out), 16'(expc));
    chk("busy@t0", 16'(bus.busy), 16'd1);
    if (junk) begin
      bus.req_target = 8'h0F;
      bus.req_valid  = 1'b1;
    end
    for (int t = 1; t <= t_last; t++) begin
      if (t == t_done) bus.req_valid = 1'b0;
      step();
      if (t == 1) expc = v;
      if (t == 2 && pw != 8'h00) expc = v & ~pw;
      for (int k = 0; k < n; k++) if (t == t_rel[k]) expc = v_rel[k];
      chk($sformatf("ctrl@t%0d", t), 16'(bus.ctrl_out), 16'(expc));
      chk($sformatf("done@t%0d", t), 16'(bus.done), 16'(t == t_done));
      chk($sformatf("busy@t%0d", t), 16'(bus.busy), 16'(t != t_done));
    end
    bus.req_valid = 1'b0;
    m_ctrl = expc;
  endtask

  task automatic request(input logic [7:0] tgt, input logic [7:0] eff, input int stop_t, input bit junk);
    chk("ready_before_req", 16'(bus.req_ready), 16'd1);
    bus.req_target = tgt;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid  = 1'b0;
    run_seq(eff, stop_t, junk);
  endtask

  initial begin
    logic [7:0] tgt;
    bus.req_target        = 8'h00;
    bus.req_valid         = 1'b0;
    bus.suspend           = 1'b0;
    bus.ci_overcurrent_n  = 1'b1;
    bus.tps_overcurrent_n = 1'b1;
    bus.fault_clr         = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_ctrl", 16'(bus.ctrl_out), 16'hFF);
    chk("rst_fault", 16'(bus.fault), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 16'(bus.req_ready), 16'd1);
    m_ctrl = 8'hFF;

    // Full power-up, then full power-down, then power-up with a held stray request
    request(8'h00, 8'h00, 0, 1'b0);
    chk("t1_final", 16'(bus.ctrl_out), 16'h00);
    request(8'hFF, 8'hFF, 0, 1'b0);
    request(8'h00, 8'h00, 0, 1'b1);
    step();
    chk("t3_not_queued", 16'(bus.busy), 16'd0);
    chk("t3_final", 16'(bus.ctrl_out), 16'h00);

    // Suspend in the middle of the reset gaps, then replay on resume
    request(8'hFF, 8'hFF, 0, 1'b0);
    request(8'h00, 8'h00, 11, 1'b0);
    bus.suspend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("susp_ctrl", 16'(bus.ctrl_out), 16'hFF);
      chk("susp_done", 16'(bus.done), 16'd0);
      chk("susp_ready", 16'(bus.req_ready), 16'd0);
    end
    bus.suspend = 1'b0;
    step();
    m_ctrl = 8'hFF;
    run_seq(8'h00, 0, 1'b0);

    // CI overcurrent: a short glitch is filtered, a long one faults
    bus.ci_overcurrent_n = 1'b0;
    step();
    step();
    bus.ci_overcurrent_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("glitch_fault", 16'(bus.fault), 16'd0);
      chk("glitch_ctrl", 16'(bus.ctrl_out), 16'h00);
    end
    bus.ci_overcurrent_n = 1'b0;
    for (int t = 1; t <= SYNC + OF; t++) begin
      step();
      chk($sformatf("ci_fault@%0d", t), 16'(bus.fault), (t >= SYNC + OF) ? 16'd1 : 16'd0);
      chk($sformatf("ci_ctrl@%0d", t), 16'(bus.ctrl_out), (t >= SYNC + OF) ? 16'h40 : 16'h00);
    end
    bus.ci_overcurrent_n = 1'b1;
    step();
    m_ctrl = 8'h40;
    request(8'h00, 8'h40, 0, 1'b0);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk("ci_clr_fault", 16'(bus.fault), 16'd0);
    chk("ci_clr_keeps_off", 16'(bus.ctrl_out), 16'h40);
    request(8'h00, 8'h00, 0, 1'b0);

    // TPS overcurrent, with a clear arriving while the fault is still present
    bus.tps_overcurrent_n = 1'b0;
    for (int t = 1; t <= SYNC + OF; t++) step();
    chk("tps_fault", 16'(bus.fault), 16'd2);
    chk("tps_ctrl", 16'(bus.ctrl_out), 16'h20);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk("fault_beats_clr", 16'(bus.fault), 16'd2);
    bus.tps_overcurrent_n = 1'b1;
    step();
    step();
    step();
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk("tps_clr_fault", 16'(bus.fault), 16'd0);
`ifdef FE_SEQ_OC_COUNT_EN
    chk("oc_count", bus.oc_count, 16'h0101);
`endif
    m_ctrl = 8'h20;

    // Randomized targets against the timeline model
    for (int r = 0; r < 16; r++) begin
      tgt = 8'($urandom);
      request(tgt, tgt, 0, 1'($urandom_range(0, 1)));
      chk("rand_final", 16'(bus.ctrl_out), 16'(tgt));
    end

    // Asynchronous reset during the power settle wait
    request(8'hFF, 8'hFF, 0, 1'b0);
    request(8'h00, 8'h00, 5, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_ctrl", 16'(bus.ctrl_out), 16'hFF);
    chk("async_rst_ready", 16'(bus.req_ready), 16'd1);
    chk("async_rst_busy", 16'(bus.busy), 16'd0);
    step();
    reset = 1'b0;
    step();
    chk("after_rst_ctrl", 16'(bus.ctrl_out), 16'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
